opnd_fetch: RTL and testbench
=============================

OPND_FETCH -- requirements
Module: opnd_fetch

Interface
REQ-001 SHALL: clk  input  1  clock; all registers update on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: stall_i, flush_i  input  1 each  hold / clear request from the pipeline controller.
REQ-004 SHALL: id_valid_i  input  1  ID-stage instruction valid.
REQ-005 SHALL: id_inst_i  input  32  instruction word; rs = [25:21], rt = [20:16].
REQ-006 SHALL: id_use_rs_i, id_use_rt_i  input  1 each  decoder says operand 1 / operand 2 is read from a register.
REQ-007 SHALL: re1_o, re2_o  output  1 each  register-file read enables.
REQ-008 SHALL: raddr1_o, raddr2_o  output  5 each  register-file read addresses.
REQ-009 SHALL: rdata1_i, rdata2_i  input  32 each  register-file read data; WB-stage bypass is already applied by the register file.
REQ-010 SHALL: ex_we_i, ex_load_i  input  1 each  EX-stage write enable / EX instruction is a load.
REQ-011 SHALL: ex_waddr_i  input  5, ex_wdata_i  input  32  EX-stage destination and result.
REQ-012 SHALL: mem_we_i  input  1, mem_waddr_i  input  5, mem_wdata_i  input  32  MEM-stage destination and result.
REQ-013 SHALL: stall_req_o  output  1  load-use hazard stall request.
REQ-014 SHALL: ex_valid_o  output  1, ex_inst_o  output  32  registered instruction to EX.
REQ-015 SHALL: ex_opnd1_o, ex_opnd2_o  output  32 each  registered resolved operands.
REQ-016 SHALL: stall_cnt_o  output  16  count of hazard-bubble cycles, saturating.

Function
REQ-017 SHALL: re1_o = id_valid_i & id_use_rs_i and raddr1_o = id_inst_i[25:21], combinationally; the same holds for port 2 with rt.
REQ-018 SHALL: resolve each operand with this priority: read disabled -> 0; address 0 -> 0; EX match (ex_we_i, ex_waddr_i == addr, !ex_load_i) -> ex_wdata_i; MEM match (mem_we_i, mem_waddr_i == addr) -> mem_wdata_i; otherwise -> rdata_i.
REQ-019 SHALL: when EX and MEM both match the same address, EX wins.
REQ-020 SHALL: raise hazard when either read is enabled, its address != 0, ex_we_i = 1, ex_load_i = 1 and ex_waddr_i equals that address.
REQ-021 SHALL: drive stall_req_o = hazard combinationally, with zero latency.
REQ-022 SHALL: FSM states RUN and BUBBLE.
- RUN -> BUBBLE on a clock edge with hazard & !stall_i & !flush_i.
- BUBBLE -> RUN on the next edge, unconditionally; the load is then in MEM and the MEM forward applies.
REQ-023 SHALL: update the pipeline register in this priority order:
- rst or flush_i -> clear all fields to 0;
- else stall_i -> hold all fields;
- else hazard -> insert bubble (ex_valid_o = 0, ex_inst_o = 0, operands = 0);
- else capture id_valid_i, id_inst_i and the resolved operands.
REQ-024 SHALL: when id_valid_i = 0, capture a bubble with all fields 0.
REQ-025 SHALL: increment stall_cnt_o by 1 on each edge that inserts a hazard bubble, and saturate at 16'hFFFF.
REQ-026 SHALL: give stall_i and flush_i priority over hazard; a flush while hazard is asserted clears the register and leaves the FSM in RUN.

Reset
REQ-027 SHALL: on rst, set ex_valid_o, ex_inst_o, ex_opnd1_o, ex_opnd2_o and stall_cnt_o to 0 and the FSM to RUN.
REQ-028 SHALL: a reset mid-BUBBLE returns to RUN with no pending stall.
REQ-029 SHALL: stall_req_o and the read ports remain combinational during reset, and no register captures data while rst = 1.

Verification
REQ-030 SHALL: no match, rdata1_i = 32'h11, rdata2_i = 32'h22, inst rs = 3, rt = 4 -> next edge ex_opnd1_o = 32'h11, ex_opnd2_o = 32'h22, ex_valid_o = 1.
REQ-031 SHALL: EX writes r3 = 32'hAA and MEM writes r3 = 32'hBB, rs = 3 -> ex_opnd1_o = 32'hAA; with EX disabled -> 32'hBB.
REQ-032 SHALL: EX load to r5, inst rs = 5 -> stall_req_o = 1, next edge ex_valid_o = 0, stall_cnt_o = 1; following cycle with MEM forward r5 = 32'hCC -> ex_opnd1_o = 32'hCC, ex_valid_o = 1.
REQ-033 SHALL: rs = 0 with EX writing r0 = 32'hFF -> ex_opnd1_o = 0 and stall_req_o = 0.
REQ-034 SHALL: stall_i = 1 for 3 cycles while inputs change -> outputs held; flush_i = 1 during hazard -> all outputs 0 and FSM in RUN.
REQ-035 SHALL: preload stall_cnt_o = 16'hFFFE via repeated hazards, then 2 more hazards -> stall_cnt_o = 16'hFFFF.

Source files
------------

// File: rtl/opnd_fetch.sv
// Operand fetch / ID-to-EX pipeline register: register-file read ports, EX/MEM
// forwarding, load-use hazard detection with a one-cycle bubble, saturating stall counter.
`timescale 1ns/1ps

module opnd_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        id_valid_i,
  input  logic [31:0] id_inst_i,
  input  logic        id_use_rs_i,
  input  logic        id_use_rt_i,
  output logic        re1_o,
  output logic        re2_o,
  output logic [4:0]  raddr1_o,
  output logic [4:0]  raddr2_o,
  input  logic [31:0] rdata1_i,
  input  logic [31:0] rdata2_i,
  input  logic        ex_we_i,
  input  logic        ex_load_i,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        mem_we_i,
  input  logic [4:0]  mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        stall_req_o,
  output logic        ex_valid_o,
  output logic [31:0] ex_inst_o,
  output logic [31:0] ex_opnd1_o,
  output logic [31:0] ex_opnd2_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] BUBBLE = 1'b1;

  logic [0:0]  r_state;
  logic        r_ex_valid;
  logic [31:0] r_ex_inst;
  logic [31:0] r_ex_opnd1;
  logic [31:0] r_ex_opnd2;
  logic [15:0] r_stall_cnt;

  logic        w_re1;
  logic        w_re2;
  logic [4:0]  w_raddr1;
  logic [4:0]  w_raddr2;
  logic [31:0] w_opnd1;
  logic [31:0] w_opnd2;
  logic        w_haz1;
  logic        w_haz2;
  logic        w_hazard;
  logic        w_insert_bubble;

  // A load in EX has no data yet, so it is never a forwarding source; that case
  // is covered by the bubble instead, after which the MEM forward supplies it.
  function automatic logic [31:0] f_resolve(
    input logic        en,
    input logic [4:0]  addr,
    input logic        ex_we,
    input logic        ex_load,
    input logic [4:0]  ex_waddr,
    input logic [31:0] ex_wdata,
    input logic        mem_we,
    input logic [4:0]  mem_waddr,
    input logic [31:0] mem_wdata,
    input logic [31:0] rdata
  );
    logic [31:0] v;
    v = rdata;
    if (!en || addr == 5'd0)
      v = 32'd0;
    else if (ex_we && !ex_load && ex_waddr == addr)
      v = ex_wdata;
    else if (mem_we && mem_waddr == addr)
      v = mem_wdata;
    return v;
  endfunction

  assign w_re1    = id_valid_i & id_use_rs_i;
  assign w_re2    = id_valid_i & id_use_rt_i;
  assign w_raddr1 = id_inst_i[25:21];
  assign w_raddr2 = id_inst_i[20:16];

  assign w_opnd1 = f_resolve(w_re1, w_raddr1, ex_we_i, ex_load_i, ex_waddr_i, ex_wdata_i,
                             mem_we_i, mem_waddr_i, mem_wdata_i, rdata1_i);
  assign w_opnd2 = f_resolve(w_re2, w_raddr2, ex_we_i, ex_load_i, ex_waddr_i, ex_wdata_i,
                             mem_we_i, mem_waddr_i, mem_wdata_i, rdata2_i);

  assign w_haz1 = w_re1 && (w_raddr1 != 5'd0) && ex_we_i && ex_load_i && (ex_waddr_i == w_raddr1);
  assign w_haz2 = w_re2 && (w_raddr2 != 5'd0) && ex_we_i && ex_load_i && (ex_waddr_i == w_raddr2);
  assign w_hazard = w_haz1 | w_haz2;

  // Stall and flush outrank the hazard: only an otherwise-free edge inserts a bubble.
  assign w_insert_bubble = w_hazard & ~stall_i & ~flush_i;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; reset is synchronous here, so it appears inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      case (r_state)
        RUN:     r_state <= w_insert_bubble ? BUBBLE : RUN;
        BUBBLE:  r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      r_ex_valid <= 1'b0;
      r_ex_inst  <= 32'd0;
      r_ex_opnd1 <= 32'd0;
      r_ex_opnd2 <= 32'd0;
    end else if (stall_i) begin
      r_ex_valid <= r_ex_valid;
      r_ex_inst  <= r_ex_inst;
      r_ex_opnd1 <= r_ex_opnd1;
      r_ex_opnd2 <= r_ex_opnd2;
    end else if (w_hazard || !id_valid_i) begin
      r_ex_valid <= 1'b0;
      r_ex_inst  <= 32'd0;
      r_ex_opnd1 <= 32'd0;
      r_ex_opnd2 <= 32'd0;
    end else begin
      r_ex_valid <= 1'b1;
      r_ex_inst  <= id_inst_i;
      r_ex_opnd1 <= w_opnd1;
      r_ex_opnd2 <= w_opnd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_stall_cnt <= 16'd0;
    else if (w_insert_bubble && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign re1_o       = w_re1;
  assign re2_o       = w_re2;
  assign raddr1_o    = w_raddr1;
  assign raddr2_o    = w_raddr2;
  assign stall_req_o = w_hazard;
  assign ex_valid_o  = r_ex_valid;
  assign ex_inst_o   = r_ex_inst;
  assign ex_opnd1_o  = r_ex_opnd1;
  assign ex_opnd2_o  = r_ex_opnd2;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_opnd_fetch.sv
// Directed bench for opnd_fetch: one task per scenario, inline comparisons
// against hand-computed values, single summary line at the end.
`timescale 1ns/1ps

module tb_opnd_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        flush_i;
  logic        id_valid_i;
  logic [31:0] id_inst_i;
  logic        id_use_rs_i;
  logic        id_use_rt_i;
  logic        re1_o;
  logic        re2_o;
  logic [4:0]  raddr1_o;
  logic [4:0]  raddr2_o;
  logic [31:0] rdata1_i;
  logic [31:0] rdata2_i;
  logic        ex_we_i;
  logic        ex_load_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        mem_we_i;
  logic [4:0]  mem_waddr_i;
  logic [31:0] mem_wdata_i;
  logic        stall_req_o;
  logic        ex_valid_o;
  logic [31:0] ex_inst_o;
  logic [31:0] ex_opnd1_o;
  logic [31:0] ex_opnd2_o;
  logic [15:0] stall_cnt_o;

  int total = 0;
  int bad   = 0;

  opnd_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .flush_i     (flush_i),
    .id_valid_i  (id_valid_i),
    .id_inst_i   (id_inst_i),
    .id_use_rs_i (id_use_rs_i),
    .id_use_rt_i (id_use_rt_i),
    .re1_o       (re1_o),
    .re2_o       (re2_o),
    .raddr1_o    (raddr1_o),
    .raddr2_o    (raddr2_o),
    .rdata1_i    (rdata1_i),
    .rdata2_i    (rdata2_i),
    .ex_we_i     (ex_we_i),
    .ex_load_i   (ex_load_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_wdata_i  (ex_wdata_i),
    .mem_we_i    (mem_we_i),
    .mem_waddr_i (mem_waddr_i),
    .mem_wdata_i (mem_wdata_i),
    .stall_req_o (stall_req_o),
    .ex_valid_o  (ex_valid_o),
    .ex_inst_o   (ex_inst_o),
    .ex_opnd1_o  (ex_opnd1_o),
    .ex_opnd2_o  (ex_opnd2_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h23, rs, rt, 16'h1234};
  endfunction

  task automatic idle();
    rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    id_valid_i = 1'b0; id_inst_i = 32'd0; id_use_rs_i = 1'b0; id_use_rt_i = 1'b0;
    rdata1_i = 32'd0; rdata2_i = 32'd0;
    ex_we_i = 1'b0; ex_load_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'd0;
    mem_we_i = 1'b0; mem_waddr_i = 5'd0; mem_wdata_i = 32'd0;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    id_valid_i = 1'b1; id_inst_i = mk_inst(5'd3, 5'd4); id_use_rs_i = 1'b1;
    rdata1_i = 32'h55; rst = 1'b1;
    tick(); tick();
    total++; if (ex_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ex_valid_o); end
    total++; if (ex_inst_o !== 32'd0) begin bad++; $display("FAIL reset_inst got=%h exp=0", ex_inst_o); end
    total++; if (ex_opnd1_o !== 32'd0 || ex_opnd2_o !== 32'd0) begin
      bad++; $display("FAIL reset_opnd got=%h/%h exp=0/0", ex_opnd1_o, ex_opnd2_o); end
    total++; if (stall_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", stall_cnt_o); end
    total++; if (re1_o !== 1'b1 || raddr1_o !== 5'd3) begin
      bad++; $display("FAIL reset_readport got=%b/%0d exp=1/3", re1_o, raddr1_o); end
    rst = 1'b0;
  endtask

  task automatic test_basic_read();
    idle();
    id_valid_i = 1'b1; id_inst_i = mk_inst(5'd3, 5'd4);
    id_use_rs_i = 1'b1; id_use_rt_i = 1'b1;
    rdata1_i = 32'h11; rdata2_i = 32'h22;
    #1;
    total++; if (re1_o !== 1'b1 || re2_o !== 1'b1 || raddr1_o !== 5'd3 || raddr2_o !== 5'd4) begin
      bad++; $display("FAIL basic_ports got=%b%b/%0d/%0d exp=11/3/4", re1_o, re2_o, raddr1_o, raddr2_o); end
    tick();
    total++; if (ex_opnd1_o !== 32'h11) begin bad++; $display("FAIL basic_opnd1 got=%h exp=11", ex_opnd1_o); end
    total++; if (ex_opnd2_o !== 32'h22) begin bad++; $display("FAIL basic_opnd2 got=%h exp=22", ex_opnd2_o); end
    total++; if (ex_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", ex_valid_o); end
    total++; if (ex_inst_o !== 32'h8C641234) begin bad++; $display("FAIL basic_inst got=%h exp=8c641234", ex_inst_o); end
  endtask

  task automatic test_forward_priority();
    idle();
    id_valid_i = 1'b1; id_inst_i = mk_inst(5'd3, 5'd3);
    id_use_rs_i = 1'b1; id_use_rt_i = 1'b1;
    rdata1_i = 32'h77; rdata2_i = 32'h78;
    ex_we_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'hAA;
    mem_we_i = 1'b1; mem_waddr_i = 5'd3; mem_wdata_i = 32'hBB;
    tick();
    total++; if (ex_opnd1_o !== 32'hAA) begin bad++; $display("FAIL fwd_ex_wins1 got=%h exp=aa", ex_opnd1_o); end
    total++; if (ex_opnd2_o !== 32'hAA) begin bad++; $display("FAIL fwd_ex_wins2 got=%h exp=aa", ex_opnd2_o); end
    ex_we_i = 1'b0;
    tick();
    total++; if (ex_opnd1_o !== 32'hBB) begin bad++; $display("FAIL fwd_mem got=%h exp=bb", ex_opnd1_o); end
    mem_we_i = 1'b0;
    tick();
    total++; if (ex_opnd2_o !== 32'h78) begin bad++; $display("FAIL fwd_none got=%h exp=78", ex_opnd2_o); end
    // Read disabled on port 1: zero even though MEM matches.
    mem_we_i = 1'b1; id_use_rs_i = 1'b0;
    tick();
    total++; if (ex_opnd1_o !== 32'd0 || ex_opnd2_o !== 32'hBB) begin
      bad++; $display("FAIL fwd_disabled got=%h/%h exp=0/bb", ex_opnd1_o, ex_opnd2_o); end
  endtask

  task automatic test_zero_reg();
    idle();
    id_valid_i = 1'b1; id_inst_i = mk_inst(5'd0, 5'd0);
    id_use_rs_i = 1'b1; id_use_rt_i = 1'b1; rdata1_i = 32'h99;
    ex_we_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hFF;
    #1;
    total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL zero_nostall got=%b exp=0", stall_req_o); end
    tick();
    total++; if (ex_opnd1_o !== 32'd0) begin bad++; $display("FAIL zero_opnd1 got=%h exp=0", ex_opnd1_o); end
    ex_load_i = 1'b1;
    #1;
    total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL zero_load_nostall got=%b exp=0", stall_req_o); end
  endtask

  task automatic test_load_use();
    idle();
    id_valid_i = 1'b1; id_inst_i = mk_inst(5'd5, 5'd6); id_use_rs_i = 1'b1;
    rdata1_i = 32'h99;
    ex_we_i = 1'b1; ex_load_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h44;
    #1;
    total++; if (stall_req_o !== 1'b1) begin bad++; $display("FAIL lu_stallreq got=%b exp=1", stall_req_o); end
    tick();
    total++; if (ex_valid_o !== 1'b0 || ex_opnd1_o !== 32'd0) begin
      bad++; $display("FAIL lu_bubble got=%b/%h exp=0/0", ex_valid_o, ex_opnd1_o); end
    total++; if (stall_cnt_o !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt_o); end
    total++; if (dut.r_state !== 1'b1) begin bad++; $display("FAIL lu_state_bubble got=%b exp=1", dut.r_state); end
    ex_we_i = 1'b0; ex_load_i = 1'b0;
    mem_we_i = 1'b1; mem_waddr_i = 5'd5; mem_wdata_i = 32'hCC;
    #1;
    total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL lu_release got=%b exp=0", stall_req_o); end
    tick();
    total++; if (ex_opnd1_o !== 32'hCC || ex_valid_o !== 1'b1) begin
      bad++; $display("FAIL lu_memfwd got=%h/%b exp=cc/1", ex_opnd1_o, ex_valid_o); end
    total++; if (stall_cnt_o !== 16'd1 || dut.r_state !== 1'b0) begin
      bad++; $display("FAIL lu_after got=%0d/%b exp=1/0", stall_cnt_o, dut.r_state); end
  endtask

  task automatic test_stall_hold();
    idle();
    id_valid_i = 1'b1; id_inst_i = mk_inst(5'd7, 5'd8);
    id_use_rs_i = 1'b1; id_use_rt_i = 1'b1;
    rdata1_i = 32'h1234_5678; rdata2_i = 32'h9ABC_DEF0;
    tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_inst_i = mk_inst(5'd9 + 5'(i), 5'd8);
      rdata1_i = 32'hDEAD_0000 + 32'(i); rdata2_i = 32'hBEEF_0000 + 32'(i);
      // Hazard present on the last stalled cycle: must not count.
      if (i == 2) begin ex_we_i = 1'b1; ex_load_i = 1'b1; ex_waddr_i = 5'd11; end
      tick();
      total++; if (ex_opnd1_o !== 32'h1234_5678 || ex_opnd2_o !== 32'h9ABC_DEF0 ||
                   ex_inst_o !== 32'h8CE8_1234 || ex_valid_o !== 1'b1) begin
        bad++; $display("FAIL stall_hold%0d got=%h/%h/%h exp=12345678/9abcdef0/8ce81234",
                        i, ex_opnd1_o, ex_opnd2_o, ex_inst_o); end
    end
    total++; if (stall_cnt_o !== 16'd1) begin bad++; $display("FAIL stall_nocount got=%0d exp=1", stall_cnt_o); end
  endtask

  task automatic test_flush_hazard();
    idle();
    id_valid_i = 1'b1; id_inst_i = mk_inst(5'd2, 5'd3); id_use_rs_i = 1'b1; rdata1_i = 32'h31;
    tick();
    ex_we_i = 1'b1; ex_load_i = 1'b1; ex_waddr_i = 5'd2; flush_i = 1'b1;
    tick();
    total++; if (ex_valid_o !== 1'b0 || ex_inst_o !== 32'd0 || ex_opnd1_o !== 32'd0 || ex_opnd2_o !== 32'd0) begin
      bad++; $display("FAIL flush_clear got=%b/%h/%h exp=0/0/0", ex_valid_o, ex_inst_o, ex_opnd1_o); end
    total++; if (dut.r_state !== 1'b0 || stall_cnt_o !== 16'd1) begin
      bad++; $display("FAIL flush_state got=%b/%0d exp=0/1", dut.r_state, stall_cnt_o); end
  endtask

  task automatic test_invalid_bubble();
    idle();
    id_valid_i = 1'b0; id_inst_i = mk_inst(5'd4, 5'd5);
    id_use_rs_i = 1'b1; id_use_rt_i = 1'b1; rdata1_i = 32'h41; rdata2_i = 32'h51;
    #1;
    total++; if (re1_o !== 1'b0 || re2_o !== 1'b0) begin bad++; $display("FAIL inv_re got=%b%b exp=00", re1_o, re2_o); end
    tick();
    total++; if (ex_valid_o !== 1'b0 || ex_inst_o !== 32'd0 || ex_opnd1_o !== 32'd0 || ex_opnd2_o !== 32'd0) begin
      bad++; $display("FAIL inv_bubble got=%b/%h/%h/%h exp=0/0/0/0", ex_valid_o, ex_inst_o, ex_opnd1_o, ex_opnd2_o); end
  endtask

  task automatic test_reset_mid_bubble();
    idle();
    id_valid_i = 1'b1; id_inst_i = mk_inst(5'd6, 5'd0); id_use_rs_i = 1'b1;
    ex_we_i = 1'b1; ex_load_i = 1'b1; ex_waddr_i = 5'd6;
    tick();
    rst = 1'b1;
    tick();
    total++; if (dut.r_state !== 1'b0 || stall_cnt_o !== 16'd0 || ex_valid_o !== 1'b0) begin
      bad++; $display("FAIL rstbub_state got=%b/%0d/%b exp=0/0/0", dut.r_state, stall_cnt_o, ex_valid_o); end
    total++; if (stall_req_o !== 1'b1) begin bad++; $display("FAIL rstbub_comb_stall got=%b exp=1", stall_req_o); end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    id_valid_i = 1'b1; id_inst_i = mk_inst(5'd5, 5'd0); id_use_rs_i = 1'b1;
    ex_we_i = 1'b1; ex_load_i = 1'b1; ex_waddr_i = 5'd5;
    repeat (65534) @(posedge clk);
    #1;
    total++; if (stall_cnt_o !== 16'hFFFE) begin bad++; $display("FAIL sat_preload got=%h exp=fffe", stall_cnt_o); end
    tick();
    total++; if (stall_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffff", stall_cnt_o); end
    tick();
    total++; if (stall_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_read();
    test_forward_priority();
    test_zero_reg();
    test_load_use();
    test_stall_hold();
    test_flush_hazard();
    test_invalid_bubble();
    test_reset_mid_bubble();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
